// File: rtl/dpram_clr.sv
// Single-clock true dual-port RAM with byte lanes, chip selects and A-wins collision handling.
// Define DPRAM_CLEAR_EN to build in the hardware clear sequencer (CLR/BUSY).
module dpram_clr #(
  parameter int unsigned ADDR_DEPTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_DEPTH-1:0]   AA,
  input  logic [DATA_WIDTH-1:0]   AI,
  input  logic                    ACS,
  input  logic                    AWE,
  input  logic [DATA_WIDTH/8-1:0] ABE,
  output logic [DATA_WIDTH-1:0]   AO,
  input  logic [ADDR_DEPTH-1:0]   BA,
  input  logic [DATA_WIDTH-1:0]   BI,
  input  logic                    BCS,
  input  logic                    BWE,
  input  logic [DATA_WIDTH/8-1:0] BBE,
  output logic [DATA_WIDTH-1:0]   BO,
  input  logic                    CLR,
  output logic                    BUSY
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_DEPTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] ao_q, bo_q;
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_DEPTH-1:0] clr_addr;
  logic                  a_en, b_en, a_wen, b_wen;

`ifdef DPRAM_CLEAR_EN
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e                state_q;
  logic [ADDR_DEPTH-1:0] cnt_q, cnt_d;
  logic                  busy_q;

  assign cnt_d = cnt_q + ADDR_DEPTH'(1);

  // Clear sequencer: sweeps every address once, BUSY drops on the last write edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CLR) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (&cnt_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;
`else
  logic unused_clr;

  assign unused_clr = CLR;
  assign busy       = 1'b0;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
`endif

  assign a_en  = ACS & ~busy;
  assign b_en  = BCS & ~busy;
  assign a_wen = a_en & AWE;
  assign b_wen = b_en & BWE;

  // Storage: B lanes first so port A overrides on shared lanes at the same address.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (b_wen && BBE[i]) mem_q[BA][8*i +: 8] <= BI[8*i +: 8];
        if (a_wen && ABE[i]) mem_q[AA][8*i +: 8] <= AI[8*i +: 8];
      end
    end
  end

  // Read-first registered outputs; hold when deselected or busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ao_q <= '0;
      bo_q <= '0;
    end else begin
      if (a_en) ao_q <= mem_q[AA];
      if (b_en) bo_q <= mem_q[BA];
    end
  end

  assign AO   = ao_q;
  assign BO   = bo_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_dpram_clr.sv
// Directed bench for dpram_clr (ADDR_DEPTH=4, DATA_WIDTH=16); covers both DPRAM_CLEAR_EN builds.
module tb_dpram_clr;

  localparam logic [15:0] CV = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [3:0]  aa, ba;
  logic [15:0] ai, bi, ao, bo;
  logic        acs, awe, bcs, bwe, busy;
  logic [1:0]  abe, bbe;

  int total = 0;
  int bad   = 0;

  dpram_clr #(.ADDR_DEPTH(4), .DATA_WIDTH(16), .CLEAR_VALUE(CV)) dut (
    .CLK(clk), .RST(rst),
    .AA(aa), .AI(ai), .ACS(acs), .AWE(awe), .ABE(abe), .AO(ao),
    .BA(ba), .BI(bi), .BCS(bcs), .BWE(bwe), .BBE(bbe), .BO(bo),
    .CLR(clr), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aa;  logic [15:0] ai;  logic acs; logic awe; logic [1:0] abe;
    logic [3:0]  ba;  logic [15:0] bi;  logic bcs; logic bwe; logic [1:0] bbe;
    logic        chk_a; logic [15:0] exp_a;
    logic        chk_b; logic [15:0] exp_b;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a_addr, input logic [15:0] a_dat, input logic a_cs,
                       input logic a_we, input logic [1:0] a_be,
                       input logic [3:0] b_addr, input logic [15:0] b_dat, input logic b_cs,
                       input logic b_we, input logic [1:0] b_be);
    aa = a_addr; ai = a_dat; acs = a_cs; awe = a_we; abe = a_be;
    ba = b_addr; bi = b_dat; bcs = b_cs; bwe = b_we; bbe = b_be;
  endtask

  task automatic idle();
    drive(4'd0, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 16'h0, 1'b1, 1'b0, 2'b00, 4'(15 - i), 16'h0, 1'b1, 1'b0, 2'b00);
      tick();
      check($sformatf("%s_A%0d", tag, i), 32'(ao), 32'(CV));
      check($sformatf("%s_B%0d", tag, 15 - i), 32'(bo), 32'(CV));
    end
    idle();
  endtask

  task automatic wait_busy_low(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check($sformatf("%s_timeout", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    // Memory starts all CV; each row is one edge, outputs sampled just after it.
    vt[0]  = '{4'd3, 16'h1234, 1'b1, 1'b1, 2'b11, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, CV,       1'b0, 16'h0000};
    vt[1]  = '{4'd3, 16'hABCD, 1'b1, 1'b1, 2'b01, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vt[2]  = '{4'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 16'h12CD, 1'b0, 16'h0000};
    vt[3]  = '{4'd5, 16'h1111, 1'b1, 1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 1'b1, 2'b10, 1'b1, CV,       1'b1, CV};
    vt[4]  = '{4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, 16'h1111, 1'b1, 16'h1111};
    vt[5]  = '{4'd5, 16'h1111, 1'b1, 1'b1, 2'b01, 4'd5, 16'h2222, 1'b1, 1'b1, 2'b10, 1'b1, 16'h1111, 1'b1, 16'h1111};
    vt[6]  = '{4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, 16'h2211, 1'b1, 16'h2211};
    vt[7]  = '{4'd7, 16'h0055, 1'b1, 1'b1, 2'b11, 4'd7, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, CV,       1'b1, CV};
    vt[8]  = '{4'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, 16'h12CD, 1'b1, 16'h0055};
    vt[9]  = '{4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 16'h2211, 1'b1, 16'h0055};
    vt[10] = '{4'd7, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd5, 16'hFFFF, 1'b0, 1'b1, 2'b11, 1'b1, 16'h0055, 1'b1, 16'h0055};
    vt[11] = '{4'd3, 16'h0000, 1'b0, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, 16'h0055, 1'b1, 16'h2211};
    vt[12] = '{4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 4'd9, 16'hBEEF, 1'b1, 1'b1, 2'b10, 1'b1, 16'h0055, 1'b1, CV};
    vt[13] = '{4'd9, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b1, 16'hBEC3, 1'b1, 16'hBEC3};

    idle();
    rst = 1'b0;
    clr = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    check("rst_AO", 32'(ao), 32'd0);
    check("rst_BO", 32'(bo), 32'd0);
`ifdef DPRAM_CLEAR_EN
    check("rst_BUSY", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_busy_low("init_clear", n);
    check("init_clear_cycles", 32'(n), 32'd16);
`else
    check("rst_BUSY", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), CV, 1'b1, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 1'b0, 2'b00);
      tick();
    end
    idle();
`endif
    read_all("init");

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].aa, vt[i].ai, vt[i].acs, vt[i].awe, vt[i].abe,
            vt[i].ba, vt[i].bi, vt[i].bcs, vt[i].bwe, vt[i].bbe);
      tick();
      if (vt[i].chk_a) check($sformatf("vec%0d_AO", i), 32'(ao), 32'(vt[i].exp_a));
      if (vt[i].chk_b) check($sformatf("vec%0d_BO", i), 32'(bo), 32'(vt[i].exp_b));
    end
    idle();

`ifdef DPRAM_CLEAR_EN
    // CLR pulse with port writes hammered throughout the clear.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_BUSY_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      drive(4'(n), 16'h0000, 1'b1, 1'b1, 2'b11, 4'(15 - n), 16'hFFFF, 1'b1, 1'b1, 2'b11);
      tick();
      n++;
    end
    idle();
    check("clr_cycles", 32'(n), 32'd16);
    check("clr_AO_hold", 32'(ao), 32'h0000BEC3);
    check("clr_BO_hold", 32'(bo), 32'h0000BEC3);
    read_all("after_clr");

    // Reset mid-clear at counter 9 restarts the sweep from 0.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    check("mid_BUSY", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_AO", 32'(ao), 32'd0);
    check("mid_rst_BUSY", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    wait_busy_low("restart", n);
    check("restart_cycles", 32'(n), 32'd16);
`else
    // Without the sequencer CLR is inert and ports work immediately.
    clr = 1'b1;
    drive(4'd2, 16'h4242, 1'b1, 1'b1, 2'b11, 4'd0, 16'h0, 1'b0, 1'b0, 2'b00);
    tick();
    clr = 1'b0;
    check("noclr_BUSY", 32'(busy), 32'd0);
    drive(4'd2, 16'h0, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0, 1'b1, 1'b0, 2'b00);
    tick();
    check("noclr_AO", 32'(ao), 32'h00004242);
    check("noclr_BO", 32'(bo), 32'h00004242);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_clr.md
# dpram_clr

Parametrised single-clock true dual-port RAM with per-byte write enables, chip-select gating on both ports, deterministic same-address collision rules and an optional hardware clear sequencer. Successor to the basic 2K x 8 dual-port RAM: used for VRAM/text/attribute buffers where the CPU owns port A and the video/DMA side owns port B. An asynchronous reset puts the outputs in a known state, and the clear sequencer brings memory contents to a known state.

## Interface
Parameters:
- ADDR_DEPTH, 11, address bits; depth = 2**ADDR_DEPTH words
- DATA_WIDTH, 8, word width; must be a multiple of 8
- CLEAR_VALUE, 0, word written by the clear sequencer (DATA_WIDTH bits)
- Derived: LANES = DATA_WIDTH/8

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock for both ports
- RST  in  1  asynchronous active-high reset
- AA  in  ADDR_DEPTH  port A address
- AI  in  DATA_WIDTH  port A write data
- ACS  in  1  port A select
- AWE  in  1  port A write enable (qualified by ACS)
- ABE  in  LANES  port A byte-lane enables (qualified by ACS & AWE)
- AO  out  DATA_WIDTH  port A registered read data
- BA, BI, BCS, BWE, BBE, BO: same as port A, for port B
- CLR  in  1  clear request pulse (only with DPRAM_CLEAR_EN)
- BUSY  out  1  clear in progress; port accesses ignored while high

## Operation
- Write: on a CLK rising edge with xCS=1, xWE=1, each lane i with xBE[i]=1 gets ram[xA][8i+7:8i] <= xI[8i+7:8i]. Lanes with xBE[i]=0 are unchanged.
- Read: on a CLK rising edge with xCS=1, xO <= ram[xA] (pre-edge contents).
- Same-port read during write: read-first; xO returns the old word.
- xCS=0: xO holds its previous value and no write occurs. Port B is gated by BCS.
- Cross-port same address, both writing: port A wins on lanes enabled by both ports. Lanes enabled only by B take B's data.
- Cross-port same address, one writing and the other reading: the reader gets the old word (read-first). The new word is visible the next cycle.
- Reset: AO=0, BO=0, BUSY per Configuration. RAM contents are not reset by RST alone.
- Clear sequencer states (macro on): IDLE, CLEAR.
  - RST asserted: state=CLEAR, counter=0, BUSY=1.
  - CLEAR: each cycle writes CLEAR_VALUE to ram[counter], then counter+1. On counter = 2**ADDR_DEPTH-1, the write is done and the state goes to IDLE with BUSY=0 on the same edge.
  - IDLE and CLR=1: go to CLEAR with counter=0. CLR is ignored while in CLEAR.
  - While BUSY=1: port writes are dropped, AO and BO hold, and reads are not performed.
  - RST during CLEAR: restart from address 0 after release.

## Timing
- Read latency: 1 cycle (address and select at edge N, data valid after edge N).
- Write visible to either port's read at edge N+1.
- Clear duration: exactly 2**ADDR_DEPTH cycles from the first edge after RST release or after the CLR-sampling edge, plus that sampling edge for CLR. BUSY falls on the edge that writes the last address.
- Ports may be used on the first edge where BUSY is sampled 0.
- Counter width: ADDR_DEPTH bits. No extra wrap bit; the terminal compare is on all-ones.

## Configuration
- DPRAM_CLEAR_EN defined:
  - The clear sequencer, the CLR input and the BUSY behaviour above are compiled in.
  - BUSY resets to 1.
- DPRAM_CLEAR_EN undefined:
  - No sequencer.
  - BUSY is tied to 0 and CLR is ignored (port retained, unconnected internally).
  - RAM contents are undefined after power-up.
  - Ports are usable on the first edge after RST release.

## Test plan
- Reset with macro on, ADDR_DEPTH=4 -> AO=BO=0 and BUSY=1 during RST. BUSY falls exactly 16 cycles after release. Reading all 16 addresses on A and B returns CLEAR_VALUE.
- DATA_WIDTH=16: A writes 0xABCD to addr 3 with ABE=2'b01, after 0x1234 was there -> the next read returns 0x12CD. AO on the write cycle returns 0x1234.
- Same-edge collision at addr 5, A writes 0x1111 with ABE=11 and B writes 0x2222 with BBE=10 -> ram[5]=0x1111. With ABE=01 instead -> ram[5]=0x2211.
- A writes 0x55 to addr 7 while B reads addr 7 on the same edge -> BO = old value. The next B read returns 0x55.
- BCS=0 with BA changing -> BO holds. Writes attempted while BUSY=1 after a CLR pulse -> memory afterwards is all CLEAR_VALUE.
- RST pulsed mid-clear at counter=9 -> BUSY stays 1, the clear restarts at 0, and the full 16 cycles elapse before BUSY falls.
